eth_pio_gen: RTL and testbench

- Parametrised Avalon-MM general-purpose I/O port. Successor to the single-bit output-only PIO slaves that bit-bang the Ethernet controller's SCK/CS/MOSI and sample MISO/INT.
- Adds per-bit direction, atomic set/clear, a synchronised input path, edge capture and a maskable interrupt.
- Sits on the Nios II system interconnect as an s1 slave with zero-wait-state reads; one instance replaces several 1-bit PIOs.

---
 rtl/eth_pio_gen.sv | 112 +++++++++++
 tb/tb_eth_pio_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/eth_pio_gen.sv
// General-purpose Avalon-MM I/O port for the Ethernet controller pins. It provides
// per-bit direction, atomic set/clear, synchronised inputs, edge capture and a maskable irq.
module eth_pio_gen #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] rd_word;
    logic             wr_en;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= sync_last;
        end
    end

    always_comb begin
        edge_det = sync_last ^ prev;
        if (EDGE_TYPE == 0)      edge_det = sync_last & ~prev;
        else if (EDGE_TYPE == 1) edge_det = ~sync_last & prev;
    end

    // A clear-write and a fresh edge in the same cycle leave the bit set.
    assign clr_mask = (wr_en && address == ADDR_EDGE) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE;
            dir         <= DIR_RESET;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
            if (wr_en) begin
                case (address)
                    ADDR_DATA:   data_out <= wdata;
                    ADDR_DIR:    dir      <= wdata;
                    ADDR_MASK:   irqmask  <= wdata;
                    ADDR_OUTSET: data_out <= data_out | wdata;
                    ADDR_OUTCLR: data_out <= data_out & ~wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word = (sync_last & ~dir) | (data_out & dir);
            ADDR_DIR:  rd_word = dir;
            ADDR_MASK: rd_word = irqmask;
            ADDR_EDGE: rd_word = edgecapture;
            default:   rd_word = '0;
        endcase
        readdata             = '0;
        readdata[WIDTH-1:0]  = rd_word;
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edgecapture & irqmask);

endmodule

// File: tb/tb_eth_pio_gen.sv
// Bench for eth_pio_gen: three instances (rising/falling/any edge) share one bus and pads;
// read results are checked through an expected-value queue.
module tb_eth_pio_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rdata_r, rdata_f, rdata_a;
    logic [7:0]  out_r, out_f, out_a;
    logic [7:0]  oe_r, oe_f, oe_a;
    logic        irq_r, irq_f, irq_a;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    eth_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata_r), .in_port(in_port), .out_port(out_r), .oe(oe_r), .irq(irq_r));

    eth_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata_f), .in_port(in_port), .out_port(out_f), .oe(oe_f), .irq(irq_f));

    eth_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata_a), .in_port(in_port), .out_port(out_a), .oe(oe_a), .irq(irq_a));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        if (sel == 1)      return rdata_f;
        else if (sel == 2) return rdata_a;
        return rdata_r;
    endfunction

    // Expectation is queued when the read is issued and retired when readdata settles.
    task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        address = a;
        #1;
        chk(tag_q.pop_front(), pick(sel), exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = '0; in_port = '0;
        #12;
        chk("rst_out", {24'd0, out_r}, 32'hA5);
        chk("rst_oe", {24'd0, oe_r}, 32'h0F);
        chk("rst_irq", {31'd0, irq_r}, 32'd0);
        rd(0, 3'd1, 32'h0000000F, "rst_dir_rd");
        rd(0, 3'd3, 32'h00000000, "rst_edge_rd");
        reset_n = 1'b1;
        wait_cyc(2);

        wr(3'd0, 32'hFFFF_FFF0);
        chk("out_data", {24'd0, out_r}, 32'hF0);
        wr(3'd4, 32'h0000_0003);
        chk("out_set", {24'd0, out_r}, 32'hF3);
        wr(3'd5, 32'h0000_0081);
        chk("out_clr", {24'd0, out_r}, 32'h72);
        rd(0, 3'd0, 32'h00000002, "data_mix_rd");
        rd(0, 3'd4, 32'h00000000, "outset_rd");
        rd(0, 3'd7, 32'h00000000, "rsvd_rd");
        wr(3'd6, 32'hFF);
        chk("rsvd_wr", {24'd0, out_r}, 32'h72);

        wr(3'd1, 32'h0);
        chk("oe_dir0", {24'd0, oe_r}, 32'h00);
        chk("out_keep", {24'd0, out_r}, 32'h72);
        in_port = 8'h04;
        @(posedge clk); #1;
        rd(0, 3'd0, 32'h00000000, "in_lat_k");
        @(posedge clk); #1;
        rd(0, 3'd0, 32'h00000004, "in_lat_k1");
        rd(0, 3'd3, 32'h00000000, "cap_lat_k1");
        @(posedge clk); #1;
        rd(0, 3'd3, 32'h00000004, "cap_lat_k2");
        chk("irq_masked", {31'd0, irq_r}, 32'd0);
        wr(3'd2, 32'h4);
        chk("irq_unmask", {31'd0, irq_r}, 32'd1);
        wr(3'd3, 32'h4);
        chk("irq_clr", {31'd0, irq_r}, 32'd0);
        rd(0, 3'd3, 32'h00000000, "cap_clr");

        in_port = 8'h00;
        wait_cyc(4);
        wr(3'd3, 32'hFF);
        in_port = 8'h04;
        @(posedge clk);
        wr(3'd3, 32'h4);
        rd(0, 3'd3, 32'h00000004, "set_wins");
        chk("set_wins_irq", {31'd0, irq_r}, 32'd1);

        in_port = 8'h00;
        wait_cyc(4);
        wr(3'd3, 32'hFF);
        rd(0, 3'd3, 32'h0, "clr_all_r");
        rd(1, 3'd3, 32'h0, "clr_all_f");
        rd(2, 3'd3, 32'h0, "clr_all_a");
        in_port = 8'h01;
        wait_cyc(4);
        rd(0, 3'd3, 32'h1, "rise_r");
        rd(1, 3'd3, 32'h0, "rise_f");
        rd(2, 3'd3, 32'h1, "rise_a");
        wr(3'd3, 32'h1);
        rd(2, 3'd3, 32'h0, "any_clr");
        in_port = 8'h00;
        wait_cyc(4);
        rd(0, 3'd3, 32'h0, "fall_r");
        rd(1, 3'd3, 32'h1, "fall_f");
        rd(2, 3'd3, 32'h1, "fall_a");

        wr(3'd3, 32'hFF);
        wr(3'd2, 32'hFF);
        wr(3'd0, 32'h3C);
        in_port = 8'hFF;
        wait_cyc(4);
        rd(0, 3'd3, 32'hFF, "pre_rst_cap");
        chk("pre_rst_out", {24'd0, out_r}, 32'h3C);
        chk("pre_rst_irq", {31'd0, irq_r}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_out", {24'd0, out_r}, 32'hA5);
        chk("arst_oe", {24'd0, oe_r}, 32'h0F);
        chk("arst_irq", {31'd0, irq_r}, 32'd0);
        rd(0, 3'd3, 32'h0, "arst_cap");
        rd(0, 3'd2, 32'h0, "arst_mask");
        rd(0, 3'd0, 32'h05, "arst_data");
        reset_n = 1'b1;
        wait_cyc(4);
        rd(0, 3'd3, 32'hFF, "post_rst_cap");
        chk("post_rst_irq", {31'd0, irq_r}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
